// File: rtl/riscv_core_muldiv_if.sv
// riscv_core_muldiv_if: request/result handshake bundle between the execute stage and the mul/div unit
interface riscv_core_muldiv_if #(parameter int XLEN = 64);
  logic            i_md_flush;
  logic            i_md_valid;
  logic            o_md_ready;
  logic [XLEN-1:0] i_md_srcA;
  logic [XLEN-1:0] i_md_srcB;
  logic [2:0]      i_md_control;
  logic            i_md_isword;
  logic            o_md_valid;
  logic            i_md_resready;
  logic [XLEN-1:0] o_md_result;
  logic            o_md_busy;
  modport master (
    output i_md_flush, i_md_valid, i_md_srcA, i_md_srcB, i_md_control, i_md_isword, i_md_resready,
    input  o_md_ready, o_md_valid, o_md_result, o_md_busy
  );
  modport slave (
    input  i_md_flush, i_md_valid, i_md_srcA, i_md_srcB, i_md_control, i_md_isword, i_md_resready,
    output o_md_ready, o_md_valid, o_md_result, o_md_busy
  );
endinterface

// File: rtl/riscv_core_muldiv.sv
// riscv_core_muldiv: iterative RV64M multiply/divide, one bit per cycle, valid/ready on both sides
module riscv_core_muldiv #(parameter int XLEN = 64) (
  input logic i_clk,
  input logic i_rst,
  riscv_core_muldiv_if.slave md
);
  localparam int XW = 2 * XLEN;
  localparam bit WORD_OK = (XLEN == 64);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [2:0] op;
  logic wd, neg_q, neg_r, ready, valid, busy;
  logic [6:0] count;
  logic [XW-1:0] acc, mcand;
  logic [XLEN-1:0] sh, result;
  logic [2:0] ctl;
  logic in_wd, is_div, a_neg, b_neg, a_sgn, b_sgn, div_zero, ovf;
  logic [XLEN-1:0] mask, min_w, a_mag, b_mag, spec_res;
  logic top_bit, ge;
  logic [XLEN:0] trial, diff;
  logic [XW-1:0] acc_nx, mcand_nx, prod;
  logic [XLEN-1:0] sh_nx, quo, rem, fin, result_nx;
  // sign-extend the low word to XLEN when operating in word mode
  function automatic logic [XLEN-1:0] fit(input logic w, input logic [XLEN-1:0] x);
    return w ? XLEN'($signed(x[31:0])) : x;
  endfunction
  assign md.o_md_ready  = ready;
  assign md.o_md_valid  = valid;
  assign md.o_md_busy   = busy;
  assign md.o_md_result = result;
  // accept-side decode: signedness, magnitudes and division special cases
  always_comb begin
    ctl      = md.i_md_control;
    in_wd    = md.i_md_isword & WORD_OK;
    is_div   = ctl[2];
    mask     = in_wd ? XLEN'(32'hFFFF_FFFF) : '1;
    min_w    = in_wd ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    a_neg    = in_wd ? md.i_md_srcA[31] : md.i_md_srcA[XLEN-1];
    b_neg    = in_wd ? md.i_md_srcB[31] : md.i_md_srcB[XLEN-1];
    a_sgn    = is_div ? !ctl[0] : (ctl[1:0] != 2'b11);
    b_sgn    = is_div ? !ctl[0] : !ctl[1];
    a_mag    = ((a_sgn & a_neg) ? -md.i_md_srcA : md.i_md_srcA) & mask;
    b_mag    = ((b_sgn & b_neg) ? -md.i_md_srcB : md.i_md_srcB) & mask;
    div_zero = is_div && ((md.i_md_srcB & mask) == '0);
    ovf      = is_div && !ctl[0] && ((md.i_md_srcA & mask) == min_w) && ((md.i_md_srcB & mask) == mask);
    spec_res = fit(in_wd, div_zero ? (ctl[1] ? md.i_md_srcA : '1) : (ctl[1] ? '0 : md.i_md_srcA));
  end
  // one iteration: shift-add for multiply, restoring step for divide, plus the final result select
  always_comb begin
    top_bit   = wd ? sh[31] : sh[XLEN-1];
    trial     = {acc[XLEN-1:0], top_bit};
    ge        = trial >= {1'b0, mcand[XLEN-1:0]};
    diff      = trial - {1'b0, mcand[XLEN-1:0]};
    acc_nx    = op[2] ? XW'(ge ? diff : trial) : (sh[0] ? acc + mcand : acc);
    sh_nx     = op[2] ? {sh[XLEN-2:0], ge} : sh >> 1;
    mcand_nx  = op[2] ? mcand : mcand << 1;
    prod      = neg_q ? -acc_nx : acc_nx;
    quo       = neg_q ? -sh_nx : sh_nx;
    rem       = neg_r ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    fin       = op[2] ? (op[1] ? rem : quo) : ((op[1:0] == 2'b00 || wd) ? prod[XLEN-1:0] : prod[XW-1:XLEN]);
    result_nx = fit(wd, fin);
  end
  // control FSM and datapath registers; flush wins over a same-cycle accept
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      op     <= '0;
      wd     <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      sh     <= '0;
      result <= '0;
      ready  <= 1'b1;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else if (md.i_md_flush) begin
      state <= IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else if (state == IDLE) begin
      if (md.i_md_valid) begin
        op    <= ctl;
        wd    <= in_wd;
        neg_q <= is_div ? (!ctl[0] & (a_neg ^ b_neg)) : ((a_sgn & a_neg) ^ (b_sgn & b_neg));
        neg_r <= !ctl[0] & a_neg;
        acc   <= '0;
        mcand <= is_div ? XW'(b_mag) : XW'(a_mag);
        sh    <= is_div ? a_mag : b_mag;
        count <= in_wd ? 7'd32 : 7'(XLEN);
        ready <= 1'b0;
        busy  <= 1'b1;
        if (div_zero || ovf) begin
          state  <= DONE;
          valid  <= 1'b1;
          result <= spec_res;
        end else begin
          state <= CALC;
        end
      end
    end else if (state == CALC) begin
      acc   <= acc_nx;
      sh    <= sh_nx;
      mcand <= mcand_nx;
      count <= count - 7'd1;
      if (count == 7'd1) begin
        state  <= DONE;
        valid  <= 1'b1;
        result <= result_nx;
      end
    end else if (md.i_md_resready) begin
      state <= IDLE;
      valid <= 1'b0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_riscv_core_muldiv.sv
// tb_riscv_core_muldiv: scoreboard bench with an arithmetic reference model and random + directed stimulus
module tb_riscv_core_muldiv;
  localparam int XLEN = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  riscv_core_muldiv_if #(.XLEN(XLEN)) md();
  riscv_core_muldiv #(.XLEN(XLEN)) dut (.i_clk(clk), .i_rst(rst), .md(md));
  typedef struct {logic [63:0] res; int lat;} exp_t;
  exp_t q[$];
  exp_t me;
  int checks = 0;
  int passes = 0;
  int since = -1;
  bit prev_v = 0, rdy_bad = 0, acc_now = 0, flush_now = 0;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  function automatic exp_t model(logic [2:0] op, logic w, logic [63:0] a, logic [63:0] b);
    exp_t e;
    logic [127:0] xa, xb, p;
    logic [31:0] r32;
    int sa32, sb32;
    longint sa, sb;
    bit spec = 0;
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (!op[2]) r32 = a[31:0] * b[31:0];
      else if (b[31:0] == 32'd0) begin spec = 1; r32 = op[1] ? a[31:0] : 32'hFFFF_FFFF; end
      else if (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin spec = 1; r32 = op[1] ? 32'd0 : a[31:0]; end
      else if (!op[0]) r32 = op[1] ? sa32 % sb32 : sa32 / sb32;
      else r32 = op[1] ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
      e.res = {{32{r32[31]}}, r32};
    end else begin
      sa = a;
      sb = b;
      if (!op[2]) begin
        xa = (op[1:0] != 2'b11) ? {{64{a[63]}}, a} : {64'd0, a};
        xb = !op[1] ? {{64{b[63]}}, b} : {64'd0, b};
        p = xa * xb;
        e.res = (op == 3'b000) ? p[63:0] : p[127:64];
      end
      else if (b == 64'd0) begin spec = 1; e.res = op[1] ? a : '1; end
      else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin spec = 1; e.res = op[1] ? 64'd0 : a; end
      else if (!op[0]) e.res = op[1] ? sa % sb : sa / sb;
      else e.res = op[1] ? a % b : a / b;
    end
    e.lat = spec ? 1 : (w ? 33 : 65);
    return e;
  endfunction
  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'd1;
      4: return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction
  task automatic issue(logic [2:0] op, logic w, logic [63:0] a, logic [63:0] b, bit push);
    int n = 0;
    @(negedge clk);
    while (!md.o_md_ready && n < 300) begin @(negedge clk); n++; end
    if (!md.o_md_ready) begin
      checks++;
      $display("FAIL issue_timeout: ready=0 after 300 cycles, required 1");
      return;
    end
    md.i_md_valid = 1'b1;
    md.i_md_control = op;
    md.i_md_isword = w;
    md.i_md_srcA = a;
    md.i_md_srcB = b;
    if (push) q.push_back(model(op, w, a, b));
    @(negedge clk);
    md.i_md_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 500) begin @(negedge clk); n++; end
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask
  // monitor: measures accept-to-valid latency and pops the scoreboard on each rising valid
  always @(posedge clk) begin
    acc_now = md.i_md_valid & md.o_md_ready & !md.i_md_flush & !rst;
    flush_now = md.i_md_flush;
    #1;
    if (rst || flush_now) since = -1;
    else if (acc_now) begin since = 1; rdy_bad = 0; end
    else if (since > 0) since++;
    if (since > 0) rdy_bad |= md.o_md_ready;
    if (md.o_md_valid && !prev_v) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_valid: valid=1 result %h, required valid=0", md.o_md_result);
      end else begin
        me = q.pop_front();
        chk("result", md.o_md_result, me.res);
        chk("latency", 64'(since), 64'(me.lat));
        chk("ready_low_while_busy", 64'(rdy_bad), 64'd0);
      end
      since = -1;
    end
    prev_v = md.o_md_valid;
  end
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [63:0] g;
    exp_t e;
    int n;
    md.i_md_flush = 0; md.i_md_valid = 0; md.i_md_srcA = '0; md.i_md_srcB = '0;
    md.i_md_control = '0; md.i_md_isword = 0; md.i_md_resready = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(md.o_md_ready), 64'd1);
    chk("rst_valid", 64'(md.o_md_valid), 64'd0);
    chk("rst_busy", 64'(md.o_md_busy), 64'd0);
    chk("rst_result", md.o_md_result, 64'd0);
    rst = 0;
    issue(3'b000, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1);
    issue(3'b011, 0, '1, '1, 1);
    issue(3'b001, 0, '1, '1, 1);
    issue(3'b010, 0, '1, '1, 1);
    issue(3'b100, 0, -64'd7, 64'd2, 1);
    issue(3'b110, 0, -64'd7, 64'd2, 1);
    issue(3'b101, 0, 64'd7, 64'd0, 1);
    issue(3'b111, 0, 64'd7, 64'd0, 1);
    issue(3'b100, 0, 64'h8000_0000_0000_0000, '1, 1);
    issue(3'b110, 0, 64'h8000_0000_0000_0000, '1, 1);
    issue(3'b100, 1, 64'h8000_0000, 64'hFFFF_FFFF, 1);
    issue(3'b000, 1, 64'h1_0000, 64'h1_0000, 1);
    issue(3'b101, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1);
    g = {$urandom, $urandom};
    issue(3'b101, 1, {g[63:32], 32'hFFFF_FFFE}, {g[31:0], 32'd1}, 1);
    issue(3'b000, 1, {g[31:0], 32'h1_0000}, {g[63:32], 32'h1_0000}, 1);
    issue(3'b001, 1, {g[63:32], 32'hFFFF_FFF9}, {g[31:0], 32'd3}, 1);
    issue(3'b110, 1, {g[31:0], 32'hFFFF_FFF9}, {g[63:32], 32'd2}, 1);
    drain();
    md.i_md_resready = 0;
    e = model(3'b100, 0, -64'd7, 64'd2);
    issue(3'b100, 0, -64'd7, 64'd2, 1);
    n = 0;
    while (!md.o_md_valid && n < 200) begin @(negedge clk); n++; end
    chk("bp_valid_arrives", 64'(md.o_md_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 64'(md.o_md_valid), 64'd1);
      chk("bp_result", md.o_md_result, e.res);
      chk("bp_ready", 64'(md.o_md_ready), 64'd0);
    end
    md.i_md_resready = 1;
    @(negedge clk);
    chk("bp_release_valid", 64'(md.o_md_valid), 64'd0);
    chk("bp_release_ready", 64'(md.o_md_ready), 64'd1);
    drain();
    issue(3'b000, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    repeat (19) @(negedge clk);
    md.i_md_flush = 1;
    @(posedge clk);
    #1;
    chk("flush_valid", 64'(md.o_md_valid), 64'd0);
    chk("flush_ready", 64'(md.o_md_ready), 64'd1);
    chk("flush_busy", 64'(md.o_md_busy), 64'd0);
    @(negedge clk);
    md.i_md_flush = 0;
    repeat (80) @(negedge clk);
    md.i_md_valid = 1; md.i_md_flush = 1; md.i_md_control = 3'b101; md.i_md_isword = 0;
    md.i_md_srcA = 64'd7; md.i_md_srcB = 64'd0;
    @(posedge clk);
    #1;
    chk("flush_vs_accept_busy", 64'(md.o_md_busy), 64'd0);
    chk("flush_vs_accept_ready", 64'(md.o_md_ready), 64'd1);
    @(negedge clk);
    md.i_md_valid = 0; md.i_md_flush = 0;
    repeat (5) @(negedge clk);
    issue(3'b001, 0, {$urandom, $urandom}, {$urandom, $urandom}, 0);
    repeat (30) @(negedge clk);
    #2 rst = 1;
    #1;
    chk("async_rst_ready", 64'(md.o_md_ready), 64'd1);
    chk("async_rst_valid", 64'(md.o_md_valid), 64'd0);
    chk("async_rst_busy", 64'(md.o_md_busy), 64'd0);
    chk("async_rst_result", md.o_md_result, 64'd0);
    @(negedge clk);
    rst = 0;
    repeat (70) @(negedge clk);
    for (int i = 0; i < 150; i++)
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), pick(), pick(), 1);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/riscv_core_muldiv.md
Name: riscv_core_muldiv

Overview:
- Iterative multiply/divide unit implementing the RV64M extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) plus the word forms (MULW/DIVW/DIVUW/REMW/REMUW).
- Sits beside riscv_core_alu in the execute stage. Operands are accepted through a valid/ready handshake and computed one bit per cycle.
- The result is returned through a second valid/ready handshake, so the pipeline can stall on it.

Parameters:
- XLEN, 64: datapath width; must be 32 or 64. Word mode applies only when XLEN = 64.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_md_flush  in  1  abort any in-flight operation (pipeline flush)
- i_md_valid  in  1  operation request valid
- o_md_ready  out  1  unit can accept a request
- i_md_srcA  in  XLEN  rs1 operand (multiplicand / dividend)
- i_md_srcB  in  XLEN  rs2 operand (multiplier / divisor)
- i_md_control  in  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- i_md_isword  in  1  32-bit word operation, result sign-extended
- o_md_valid  out  1  result valid
- i_md_resready  in  1  consumer accepts the result
- o_md_result  out  XLEN  result
- o_md_busy  out  1  high in CALC or DONE

Behaviour:
- Reset (i_rst high, asynchronous): state IDLE, o_md_ready=1, o_md_valid=0, o_md_busy=0, o_md_result=0, and all internal registers cleared.
- States and transitions:
  - IDLE: o_md_ready=1. On i_md_valid && o_md_ready, latch operands, op and isword.
    - Next state is DONE for a special-case division, else CALC with count = W.
    - W = 32 when isword, else XLEN.
  - CALC: process 1 bit per cycle and decrement count. When count reaches 1, go to DONE on the next edge.
  - DONE: o_md_valid=1 and o_md_result is held stable. On i_md_resready, go to IDLE.
  - No back-to-back overlap: o_md_ready=0 in CALC and DONE.
- Latency: o_md_valid rises W+1 cycles after the accept edge. For special-case divisions it rises 1 cycle after the accept edge.
- Flush: i_md_flush in any state → IDLE on the next edge, o_md_valid=0, result discarded. Flush has priority over a same-cycle accept, which is dropped.
- Reset mid-operation aborts exactly like flush, but asynchronously.
- Multiply:
  - Take operand magnitudes per signedness: MUL/MULH both operands signed, MULHSU A signed and B unsigned, MULHU both unsigned.
  - Form a 2W-bit product by shift-add.
  - Negate the product if the effective signs differ.
  - MUL returns the low W bits; MULH/MULHSU/MULHU return the high W bits.
- Divide:
  - Restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient is negated when the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- Special cases, resolved at accept with no iteration:
  - Divisor == 0: quotient = all ones (W bits), remainder = dividend.
  - Signed overflow (dividend = most-negative W-bit value, divisor = -1): quotient = dividend, remainder = 0.
- Word mode (i_md_isword=1):
  - Only srcA[31:0] and srcB[31:0] are used.
  - The 32-bit result is sign-extended from bit 31 to XLEN.
  - Control 001/010/011 with isword behaves as MULW (low word).
- Width rule: all intermediate arithmetic is W+1 or 2W bits; no truncation before the final select.
- o_md_result changes only on the transition into DONE.

Test Plan:
- MUL 7 × 0xFFFF_FFFF_FFFF_FFFD (−3) → 0xFFFF_FFFF_FFFF_FFEB; o_md_valid rises exactly 65 cycles after accept; o_md_ready low throughout.
- MULHU all-ones × all-ones → 0xFFFF_FFFF_FFFF_FFFE; MULH −1 × −1 → 0; MULHSU −1 × all-ones → 0xFFFF_FFFF_FFFF_FFFF.
- DIV −7 / 2 → 0xFFFF_FFFF_FFFF_FFFD; REM −7 % 2 → 0xFFFF_FFFF_FFFF_FFFF; DIVU 7 / 0 → all ones and REMU 7 % 0 → 7, each with valid 1 cycle after accept.
- DIV 0x8000_0000_0000_0000 / −1 → 0x8000_0000_0000_0000, REM → 0; DIVW 0x8000_0000 / 0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- Word mode:
  - MULW 0x1_0000 × 0x1_0000 → 0.
  - DIVUW 0xFFFF_FFFF_FFFF_FFFE / 1 → 0xFFFF_FFFF_FFFF_FFFE, valid 33 cycles after accept.
  - Garbage in the upper 32 bits of both sources must not affect either result.
- Backpressure and aborts:
  - Hold i_md_resready=0 for 10 cycles in DONE → result and valid stable, ready low.
  - Assert i_md_flush at CALC cycle 20 → IDLE next edge, no valid pulse, ready=1.
  - Assert i_rst mid-CALC → outputs at reset values immediately, without waiting for a clock edge.
